// File: rtl/axi_pkg.sv
// Shared AXI4 types, limits and helpers for the read host and its burst splitter.
package axi_pkg;

  localparam int AXI_4K_BOUNDARY     = 4096;
  localparam int AXI_MAX_INCR_BEATS  = 256;
  localparam int AXI_MAX_FIXED_BEATS = 16;
  localparam int AXI_CMD_ADDR_W      = 64;
  localparam int AXI_CMD_BYTES_W     = 16;

  typedef enum logic [2:0] {
    SIZE_1   = 3'd0,
    SIZE_2   = 3'd1,
    SIZE_4   = 3'd2,
    SIZE_8   = 3'd3,
    SIZE_16  = 3'd4,
    SIZE_32  = 3'd5,
    SIZE_64  = 3'd6,
    SIZE_128 = 3'd7
  } AxiSize_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } AxiBurst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } AxiResp_t;

  typedef struct packed {
    logic [AXI_CMD_ADDR_W-1:0]  addr;
    logic [AXI_CMD_BYTES_W-1:0] bytes;
    AxiSize_t                   size;
    AxiBurst_t                  burst;
  } AxiHostRdCtrl_t;

  typedef struct packed {
    AxiResp_t resp;
  } AxiHostRdStatus_t;

  function automatic logic [7:0] axiSize2bytes(input AxiSize_t size);
    return 8'd1 << size;
  endfunction

  function automatic logic axiSuccess(input AxiResp_t resp);
    return (resp == RESP_OKAY) || (resp == RESP_EXOKAY);
  endfunction

  function automatic logic axiAccepted(input logic valid, input logic ready);
    return valid && ready;
  endfunction

endpackage

// File: rtl/axi_rd_burst_calc.sv
// Combinational sizing of the next AR burst and the address that follows it.
module axi_rd_burst_calc
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] address,
  input  logic [16:0]       remaining,
  input  AxiSize_t          size,
  input  AxiBurst_t         burst,
  output logic [8:0]        burst_beats,
  output logic [ADDR_W-1:0] next_address
);

  logic [12:0] bytes_to_4k;
  logic [12:0] beats_to_4k;
  logic [16:0] cap;

  always_comb begin
    // Address is already beat-aligned here, so the shift is exact.
    bytes_to_4k = 13'(AXI_4K_BOUNDARY) - {1'b0, address[11:0]};
    beats_to_4k = bytes_to_4k >> size;
    case (burst)
      BURST_INCR:  cap = (beats_to_4k > 13'(AXI_MAX_INCR_BEATS)) ? 17'(AXI_MAX_INCR_BEATS)
                                                                 : 17'(beats_to_4k);
      BURST_FIXED: cap = 17'(AXI_MAX_FIXED_BEATS);
      default:     cap = remaining;
    endcase
    burst_beats  = (remaining < cap) ? 9'(remaining) : 9'(cap);
    next_address = (burst == BURST_INCR) ? address + (ADDR_W'(burst_beats) << size) : address;
  end

endmodule

// File: rtl/axi4_rd_host.sv
// AXI4 read host: splits one read command into legal AR bursts and streams the R beats out.
//   state   | meaning
//   S_IDLE  | cmd_ready high, waiting for a command
//   S_CHECK | validate size/alignment/burst, compute nothing on the bus
//   S_AR    | AR payload presented, waiting for arready
//   S_DATA  | R beats passed straight through to the stream
//   S_DONE  | one-cycle status pulse
module axi4_rd_host
  import axi_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  AxiHostRdCtrl_t        cmd,
  output logic                  sts_valid,
  output AxiHostRdStatus_t      sts,
  output logic [ID_W-1:0]       m_axi_arid,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_W-1:0]       m_axi_rid,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_AR, S_DATA, S_DONE} state_t;

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

  state_t           state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  AxiSize_t         size_q, size_d;
  AxiBurst_t        burst_q, burst_d;
  logic [16:0]      rem_q, rem_d;
  logic [8:0]       burst_rem_q, burst_rem_d;
  AxiResp_t         resp_q, resp_d;
  logic [ID_W-1:0]  arid_cnt_q, arid_cnt_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             sts_valid_q, sts_valid_d;
  AxiHostRdStatus_t sts_q, sts_d;
  logic             arvalid_q, arvalid_d;
  logic [ID_W-1:0]  arid_q, arid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]       arlen_q, arlen_d;
  logic [2:0]       arsize_q, arsize_d;
  logic [1:0]       arburst_q, arburst_d;

  logic [16:0]      calc_rem;
  logic [8:0]       calc_beats;
  logic [ADDR_W-1:0] calc_next_addr;
  logic [7:0]       beat_bytes;
  logic             cfg_err;
  logic             in_data;
  logic             beat;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^cmd.addr[AXI_CMD_ADDR_W-1:ADDR_W];

  // Leaving DATA for AR happens on a beat, so size the next burst on the post-beat count.
  assign calc_rem = (state_q == S_DATA) ? rem_q - 17'd1 : rem_q;

  axi_rd_burst_calc #(.ADDR_W(ADDR_W)) u_calc (
    .address      (addr_q),
    .remaining    (calc_rem),
    .size         (size_q),
    .burst        (burst_q),
    .burst_beats  (calc_beats),
    .next_address (calc_next_addr)
  );

  assign beat_bytes = axiSize2bytes(size_q);
  assign cfg_err = (size_q > MAX_SIZE)
                || ((addr_q[7:0] & (beat_bytes - 8'd1)) != 8'd0)
                || ((burst_q == BURST_WRAP) && !(rem_q inside {17'd2, 17'd4, 17'd8, 17'd16}))
                || (burst_q == BURST_RSVD);

  assign in_data       = (state_q == S_DATA);
  assign beat          = in_data && axiAccepted(m_axi_rvalid, m_axis_tready);
  assign m_axis_tvalid = in_data && m_axi_rvalid;
  assign m_axis_tdata  = in_data ? m_axi_rdata : '0;
  assign m_axis_tlast  = in_data && m_axi_rvalid && (rem_q == 17'd1);
  assign m_axi_rready  = in_data && m_axis_tready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    burst_d     = burst_q;
    rem_d       = rem_q;
    burst_rem_d = burst_rem_q;
    resp_d      = resp_q;
    arid_cnt_d  = arid_cnt_q;
    arid_d      = arid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    arburst_d   = arburst_q;
    sts_d       = sts_q;

    case (state_q)
      S_IDLE: begin
        if (axiAccepted(cmd_valid, cmd_ready_q)) begin
          addr_d  = cmd.addr[ADDR_W-1:0];
          size_d  = cmd.size;
          burst_d = cmd.burst;
          rem_d   = (17'(cmd.bytes) + 17'(axiSize2bytes(cmd.size)) - 17'd1) >> cmd.size;
          resp_d  = RESP_OKAY;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cfg_err) begin
          resp_d  = RESP_SLVERR;
          state_d = S_DONE;
        end else if (rem_q == 17'd0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_AR;
        end
      end
      S_AR: begin
        if (axiAccepted(arvalid_q, m_axi_arready)) begin
          arid_cnt_d = arid_cnt_q + 1'b1;
          addr_d     = calc_next_addr;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (beat) begin
          rem_d       = rem_q - 17'd1;
          burst_rem_d = burst_rem_q - 9'd1;
          // Only the first failure of the command is reported.
          if (resp_q == RESP_OKAY) begin
            if (!axiSuccess(AxiResp_t'(m_axi_rresp))) begin
              resp_d = AxiResp_t'(m_axi_rresp);
            end else if ((m_axi_rlast != (burst_rem_q == 9'd1)) || (m_axi_rid != arid_q)) begin
              resp_d = RESP_SLVERR;
            end
          end
          if (burst_rem_q == 9'd1) begin
            state_d = (rem_d == 17'd0) ? S_DONE : S_AR;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    sts_valid_d = (state_d == S_DONE);
    arvalid_d   = (state_d == S_AR);
    if (state_d == S_DONE) begin
      sts_d.resp = resp_d;
    end
    if ((state_d == S_AR) && (state_q != S_AR)) begin
      arid_d      = arid_cnt_q;
      araddr_d    = addr_q;
      arlen_d     = 8'(calc_beats - 9'd1);
      arsize_d    = size_q;
      arburst_d   = burst_q;
      burst_rem_d = calc_beats;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      size_q      <= SIZE_1;
      burst_q     <= BURST_FIXED;
      rem_q       <= '0;
      burst_rem_q <= '0;
      resp_q      <= RESP_OKAY;
      arid_cnt_q  <= '0;
      cmd_ready_q <= 1'b0;
      sts_valid_q <= 1'b0;
      sts_q       <= '0;
      arvalid_q   <= 1'b0;
      arid_q      <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      rem_q       <= rem_d;
      burst_rem_q <= burst_rem_d;
      resp_q      <= resp_d;
      arid_cnt_q  <= arid_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      sts_valid_q <= sts_valid_d;
      sts_q       <= sts_d;
      arvalid_q   <= arvalid_d;
      arid_q      <= arid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      arburst_q   <= arburst_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign sts_valid     = sts_valid_q;
  assign sts           = sts_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_arid    = arid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = arsize_q;
  assign m_axi_arburst = arburst_q;

endmodule

// File: tb/tb_axi4_rd_host.sv
// Bench for axi4_rd_host: randomized AR/R/stream handshakes against a burst-splitting reference model.
module tb_axi4_rd_host;
  import axi_pkg::*;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int CMD_CYCLES = 20000;

  logic               aclk = 1'b0;
  logic               aresetn = 1'b0;
  logic               cmd_valid;
  logic               cmd_ready;
  AxiHostRdCtrl_t     cmd_s;
  logic               sts_valid;
  AxiHostRdStatus_t   sts;
  logic [ID_W-1:0]    m_axi_arid;
  logic [ADDR_W-1:0]  m_axi_araddr;
  logic [7:0]         m_axi_arlen;
  logic [2:0]         m_axi_arsize;
  logic [1:0]         m_axi_arburst;
  logic               m_axi_arvalid;
  logic               m_axi_arready;
  logic [ID_W-1:0]    m_axi_rid;
  logic [DATA_W-1:0]  m_axi_rdata;
  logic [1:0]         m_axi_rresp;
  logic               m_axi_rlast;
  logic               m_axi_rvalid;
  logic               m_axi_rready;
  logic [DATA_W-1:0]  m_axis_tdata;
  logic               m_axis_tlast;
  logic               m_axis_tvalid;
  logic               m_axis_tready;

  always #5 aclk = ~aclk;

  axi4_rd_host #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd           (cmd_s),
    .sts_valid     (sts_valid),
    .sts           (sts),
    .m_axi_arid    (m_axi_arid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rid     (m_axi_rid),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  int       n_checks = 0;
  int       n_fail   = 0;
  int       exp_id   = 0;
  int       inj_beat [2];
  AxiResp_t inj_resp [2];
  int       bad_rid_beat;
  int       bad_last_beat;
  int       rst_beat;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inj();
    inj_beat[0] = -1; inj_beat[1] = -1;
    inj_resp[0] = RESP_OKAY; inj_resp[1] = RESP_OKAY;
    bad_rid_beat = -1; bad_last_beat = -1; rst_beat = -1;
  endtask

  task automatic mid_reset();
    aresetn = 1'b0;
    m_axi_rvalid = 1'b0;
    m_axi_arready = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check_eq("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    check_eq("rst_araddr", 64'(m_axi_araddr), 64'd0);
    check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_eq("rst_rready", 64'(m_axi_rready), 64'd0);
    check_eq("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check_eq("rst_sts_valid", 64'(sts_valid), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    exp_id = 0;
    @(negedge aclk);
    #1;
    check_eq("rel_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  task automatic run_cmd(input logic [31:0] addr, input int nbytes, input AxiSize_t size,
                         input AxiBurst_t burst, input int pct);
    int bb, total, rem, n, a, ar_i, beat, in_burst, cyc, cur_id;
    bit bad, accepted, done, hold;
    AxiResp_t exp_resp;
    int ar_addr [$];
    int ar_len  [$];

    // Reference: split the command by AXI rules with plain arithmetic.
    bb    = 1 << int'(size);
    total = (nbytes + bb - 1) / bb;
    bad   = (bb > DATA_W / 8) || (int'(addr) % bb != 0) ||
            (burst == BURST_WRAP && !(total inside {2, 4, 8, 16})) || (burst == BURST_RSVD);
    a   = int'(addr);
    rem = bad ? 0 : total;
    while (rem > 0) begin
      case (burst)
        BURST_INCR: begin
          n = (rem > 256) ? 256 : rem;
          if ((4096 - a % 4096) / bb < n) n = (4096 - a % 4096) / bb;
        end
        BURST_FIXED: n = (rem > 16) ? 16 : rem;
        default:     n = rem;
      endcase
      ar_addr.push_back(a);
      ar_len.push_back(n - 1);
      rem -= n;
      if (burst == BURST_INCR) a += n * bb;
    end
    exp_resp = bad ? RESP_SLVERR : RESP_OKAY;
    if (!bad) begin
      for (int b = 0; b < total; b++) begin
        if (exp_resp == RESP_OKAY) begin
          for (int k = 0; k < 2; k++)
            if (b == inj_beat[k] && inj_resp[k] inside {RESP_SLVERR, RESP_DECERR}) exp_resp = inj_resp[k];
          if (exp_resp == RESP_OKAY && (b == bad_rid_beat || b == bad_last_beat)) exp_resp = RESP_SLVERR;
        end
      end
    end

    @(negedge aclk);
    cmd_s = '{addr: 64'(addr), bytes: 16'(nbytes), size: size, burst: burst};
    cmd_valid = 1'b1;
    accepted = 0; done = 0; hold = 0;
    ar_i = 0; beat = 0; in_burst = 0; cyc = 0; cur_id = 0;
    for (int t = 0; t < CMD_CYCLES && !done; t++) begin
      if (accepted) cmd_valid = 1'b0;
      if (rst_beat >= 0 && beat == rst_beat && in_burst > 0) begin
        mid_reset();
        done = 1;
        break;
      end
      m_axi_arready = ($urandom_range(99) < pct);
      m_axis_tready = ($urandom_range(99) < pct);
      if (!hold) begin
        m_axi_rvalid = (in_burst > 0) && ($urandom_range(99) < pct);
        m_axi_rdata  = {$urandom(), $urandom()};
        m_axi_rlast  = (in_burst == 1) ^ (beat == bad_last_beat);
        m_axi_rid    = ID_W'((beat == bad_rid_beat) ? (cur_id ^ 1) : cur_id);
        m_axi_rresp  = (beat == inj_beat[0]) ? inj_resp[0] :
                       (beat == inj_beat[1]) ? inj_resp[1] : RESP_OKAY;
      end
      #1;
      if (!accepted && cmd_valid && cmd_ready) begin
        accepted = 1;
        cyc = 0;
      end
      if (accepted && sts_valid) begin
        check_eq("sts_resp", 64'(sts.resp), 64'(exp_resp));
        check_eq("sts_beats", 64'(beat), 64'(bad ? 0 : total));
        check_eq("ar_count", 64'(ar_i), 64'(ar_addr.size()));
        if (ar_addr.size() == 0) check_eq("sts_latency", 64'(cyc), 64'd2);
        done = 1;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        if (ar_i < ar_addr.size()) begin
          check_eq("araddr", 64'(m_axi_araddr), 64'(ar_addr[ar_i]));
          check_eq("arlen", 64'(m_axi_arlen), 64'(ar_len[ar_i]));
          check_eq("arid", 64'(m_axi_arid), 64'(exp_id));
          check_eq("arsize", 64'(m_axi_arsize), 64'(size));
          check_eq("arburst", 64'(m_axi_arburst), 64'(burst));
          in_burst = ar_len[ar_i] + 1;
        end else begin
          check_eq("ar_extra", 64'(ar_i), 64'(ar_addr.size()));
        end
        cur_id = exp_id;
        exp_id = (exp_id + 1) % (1 << ID_W);
        ar_i++;
      end
      if (m_axi_rvalid && m_axis_tready) begin
        check_eq("tvalid", 64'(m_axis_tvalid), 64'd1);
        check_eq("rready", 64'(m_axi_rready), 64'd1);
        check_eq("tdata", 64'(m_axis_tdata), 64'(m_axi_rdata));
        check_eq("tlast", 64'(m_axis_tlast), 64'(beat == total - 1));
        beat++;
        in_burst--;
        hold = 0;
      end else begin
        hold = m_axi_rvalid;
      end
      @(negedge aclk);
      cyc++;
    end
    check_eq("cmd_done", 64'(done), 64'd1);
    m_axi_rvalid = 1'b0;
    cmd_valid = 1'b0;
    if (rst_beat < 0) begin
      #1;
      check_eq("sts_pulse", 64'(sts_valid), 64'd0);
    end
  endtask

  initial begin
    AxiSize_t  sz;
    AxiBurst_t bu;
    logic [31:0] ra;
    int nb;

    cmd_valid = 1'b0; cmd_s = '0;
    m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0; m_axis_tready = 1'b0;
    clear_inj();

    repeat (3) @(negedge aclk);
    #1;
    check_eq("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    check_eq("reset_arvalid", 64'(m_axi_arvalid), 64'd0);
    check_eq("reset_arid", 64'(m_axi_arid), 64'd0);
    check_eq("reset_sts_valid", 64'(sts_valid), 64'd0);
    check_eq("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    #1;
    check_eq("release_cmd_ready", 64'(cmd_ready), 64'd1);

    run_cmd(32'h1000, 64, SIZE_8, BURST_INCR, 100);
    run_cmd(32'h0FF0, 64, SIZE_8, BURST_INCR, 100);
    run_cmd(32'h0000, 4096, SIZE_8, BURST_INCR, 60);
    run_cmd(32'h1003, 16, SIZE_4, BURST_INCR, 80);
    run_cmd(32'h2000, 0, SIZE_4, BURST_INCR, 80);
    run_cmd(32'h2000, 64, SIZE_16, BURST_INCR, 80);
    run_cmd(32'h2000, 24, SIZE_8, BURST_WRAP, 80);
    run_cmd(32'h2000, 24, SIZE_8, BURST_RSVD, 80);
    run_cmd(32'h0038, 64, SIZE_8, BURST_WRAP, 70);
    run_cmd(32'h0100, 80, SIZE_4, BURST_FIXED, 70);

    inj_beat[0] = 2; inj_resp[0] = RESP_DECERR;
    inj_beat[1] = 4; inj_resp[1] = RESP_SLVERR;
    run_cmd(32'h1000, 64, SIZE_8, BURST_INCR, 70);
    clear_inj();
    inj_beat[0] = 1; inj_resp[0] = RESP_EXOKAY;
    run_cmd(32'h1000, 64, SIZE_8, BURST_INCR, 70);
    clear_inj();
    bad_rid_beat = 5;
    run_cmd(32'h1000, 64, SIZE_8, BURST_INCR, 70);
    clear_inj();
    bad_last_beat = 1;
    run_cmd(32'h0FF0, 64, SIZE_8, BURST_INCR, 70);
    clear_inj();
    bad_last_beat = 0;
    run_cmd(32'h3000, 32, SIZE_4, BURST_INCR, 70);
    clear_inj();

    rst_beat = 4;
    run_cmd(32'h1000, 64, SIZE_8, BURST_INCR, 100);
    clear_inj();
    run_cmd(32'h1000, 64, SIZE_8, BURST_INCR, 100);

    for (int i = 0; i < 25; i++) begin
      clear_inj();
      sz = AxiSize_t'($urandom_range(0, 4));
      bu = AxiBurst_t'($urandom_range(0, 2));
      ra = 32'($urandom_range(0, 32'h3000));
      if ($urandom_range(9) != 0) ra = ra & ~((32'd1 << int'(sz)) - 32'd1);
      nb = $urandom_range(0, 700);
      if (bu == BURST_WRAP) nb = (1 << int'(sz)) * (2 << $urandom_range(0, 3));
      if ($urandom_range(3) == 0) begin
        inj_beat[0] = $urandom_range(0, 40);
        inj_resp[0] = AxiResp_t'($urandom_range(0, 3));
      end
      run_cmd(ra, nb, sz, bu, 70);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_rd_host.md
Name: axi4_rd_host

Overview:
- AXI4 read host: accepts one read command (AxiHostRdCtrl_t) per valid/ready handshake.
- Splits the command into legal AR bursts and issues them one at a time.
- Forwards R data beats to an AXI-Stream output with tlast on the final beat of the command.
- Reports an aggregated AxiHostRdStatus_t per command. Sits between the DMA/command logic and the AXI interconnect read channels.

Parameters:
DATA_W, 64, AXI/stream data width in bits (power of 2, 8..1024)
ADDR_W, 32, AXI address width
ID_W, 4, ARID width

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd  in  $bits(AxiHostRdCtrl_t)  address, bytes, size, burst
sts_valid  out  1  one-cycle status pulse per command
sts  out  $bits(AxiHostRdStatus_t)  aggregated response
m_axi_arid/araddr/arlen/arsize/arburst  out  ID_W/ADDR_W/8/3/2  AR payload
m_axi_arvalid  out  1; m_axi_arready  in  1
m_axi_rid  in  ID_W; m_axi_rdata  in  DATA_W; m_axi_rresp  in  2; m_axi_rlast  in  1
m_axi_rvalid  in  1; m_axi_rready  out  1
m_axis_tdata  out  DATA_W; m_axis_tlast  out  1; m_axis_tvalid  out  1; m_axis_tready  in  1

Behaviour:
- Clocking/reset: single clock aclk. Reset is asynchronous, active-low on aresetn.
- Reset values: all outputs 0; arid counter 0; state IDLE. cmd_ready goes to 1 the first cycle after reset release.
- Reset mid-operation: immediate return to IDLE. The outstanding AXI transaction is abandoned; no sts pulse.
- State machine:
  - IDLE: cmd_ready=1. On accept, register cmd, beat_bytes=1<<size, total_beats=ceil(bytes/beat_bytes) (17-bit arithmetic), go CHECK.
  - CHECK (1 cycle): error if any of: beat_bytes > DATA_W/8; address % beat_bytes != 0; burst==WRAP and total_beats not in {2,4,8,16}; burst value 3. On error go DONE with resp=SLVERR and no AR. If bytes==0, go DONE with OKAY and no AR. Otherwise go AR.
  - AR: drive arvalid=1 with arlen=burst_beats-1 and araddr=current address.
    - INCR: burst_beats = min(remaining, 256, bytes to next 4 KB boundary / beat_bytes).
    - FIXED: burst_beats = min(remaining, 16).
    - WRAP: single burst of total_beats.
    - Payload holds stable until arready. On the arvalid&&arready cycle: arid increments (wraps modulo 2^ID_W), address advances by burst_beats*beat_bytes (INCR only), go DATA.
  - DATA: pure pass-through, zero latency.
    - tvalid = rvalid; tdata = rdata; rready = tready.
    - A beat counts on rvalid&&rready.
    - tlast=1 only on the last beat of the whole command, from the internal counter (not rlast).
    - On the last beat of a burst: if remaining>0 go AR, else DONE.
  - DONE: sts_valid=1 for one cycle, then IDLE. cmd_ready is 0 everywhere except IDLE.
- Response aggregation: sts.resp holds the first non-success rresp (SLVERR/DECERR) seen in the command, else OKAY. EXOKAY is treated as OKAY.
- Protocol errors:
  - rlast==1 before the expected last beat of a burst, or rlast==0 on it: record SLVERR (if no earlier error).
  - Beat counting continues on the internal counter in both cases.
  - rid != issued arid: record SLVERR.
- Only one burst outstanding at a time. No new AR is issued until the previous burst's last beat is consumed.

Decomposition:
- axi_pkg holds: AxiSize_t, AxiBurst_t, AxiResp_t, AxiHostRdCtrl_t, AxiHostRdStatus_t, axiSize2bytes, axiSuccess, axiAccepted.
- Add to axi_pkg: constants AXI_4K_BOUNDARY=4096, AXI_MAX_INCR_BEATS=256, AXI_MAX_FIXED_BEATS=16.
- Sub-module axi_rd_burst_calc: combinational. Inputs address, remaining, size, burst; outputs burst_beats and next_address. Unit-testable alone.

Test Plan:
1. INCR, address 0x1000, bytes 64, size SIZE_8, DATA_W=64 -> one AR: arlen=7, araddr=0x1000. 8 stream beats; tlast on beat 8; sts OKAY.
2. INCR, address 0x0FF0, bytes 64, size SIZE_8 -> two ARs: 0x0FF0/arlen=1, then 0x1000/arlen=5. arid increments by 1. One tlast total.
3. INCR, address 0, bytes 4096, size SIZE_8 -> ARs arlen=255 at 0x0 and arlen=255 at 0x800. 512 beats. Random tready and rvalid gaps with no data loss.
4. Unaligned address 0x1003, size SIZE_4 -> no arvalid; sts_valid pulse with SLVERR 2 cycles after accept. bytes=0 -> OKAY, no AR.
5. Beat 3 of an 8-beat burst returns DECERR, beat 5 returns SLVERR -> all 8 beats forwarded; sts=DECERR.
6. aresetn asserted during DATA with 4 beats remaining -> all outputs 0 immediately. cmd_ready=1 after release; a new command completes normally.
